// File: rtl/lfsr_mod_rng_pkg.sv
// Shared widths, tap positions and XNOR-feedback helpers for the
// tile-pattern and speed LFSRs.
package lfsr_mod_rng_pkg;

  localparam int PAT_W = 16;
  localparam int R10_W = 10;
  localparam int SW_W  = 7;

  // Pattern polynomial x^16 + x^14 + x^13 + x^11 + 1, as register bit indices.
  localparam int PAT_TAP_A = 15;
  localparam int PAT_TAP_B = 13;
  localparam int PAT_TAP_C = 12;
  localparam int PAT_TAP_D = 10;

  // Speed polynomial x^10 + x^7 + 1, as register bit indices.
  localparam int R10_TAP_A = 9;
  localparam int R10_TAP_B = 6;

  // XNOR feedback keeps all-zero legal, so reset can simply clear the register.
  function automatic logic pat_fb(input logic [PAT_W-1:0] s);
    return ~(s[PAT_TAP_A] ^ s[PAT_TAP_B] ^ s[PAT_TAP_C] ^ s[PAT_TAP_D]);
  endfunction

  function automatic logic r10_fb(input logic [R10_W-1:0] s);
    return ~(s[R10_TAP_A] ^ s[R10_TAP_B]);
  endfunction

endpackage

// File: rtl/lfsr_mod_rng_magnitude_cmp.sv
// Unsigned 10-bit magnitude comparator: out = (a > b).
module magnitude_cmp
  import lfsr_mod_rng_pkg::*;
(
  input  logic [R10_W-1:0] a,
  input  logic [R10_W-1:0] b,
  output logic             out
);

  // Pure combinational unsigned compare, no latency.
  always_comb begin
    out = 1'b0;
    if (a > b) begin
      out = 1'b1;
    end else begin
      out = 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_mod_rng.sv
// Free-running tile-pattern LFSR (16 bit) and speed LFSR (10 bit); speed
// asserts when the 7-bit threshold exceeds the current speed LFSR value.
module lfsr_mod_rng
  import lfsr_mod_rng_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SW_W-1:0]  speed_sw,
  output logic [PAT_W-1:0] pattern,
  output logic [R10_W-1:0] rand10,
  output logic             speed
);

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [R10_W-1:0] rand10_q, rand10_d;
  logic [R10_W-1:0] speed_sw_ext_s;

  // Next-state shift for both LFSRs; they advance every cycle unconditionally.
  always_comb begin
    pattern_d = {pattern_q[PAT_W-2:0], pat_fb(pattern_q)};
    rand10_d  = {rand10_q[R10_W-2:0], r10_fb(rand10_q)};
  end

  // State registers; synchronous reset to all-zero overrides shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= {PAT_W{1'b0}};
      rand10_q  <= {R10_W{1'b0}};
    end else begin
      pattern_q <= pattern_d;
      rand10_q  <= rand10_d;
    end
  end

  // Zero-extend the threshold to the compare width.
  always_comb begin
    speed_sw_ext_s = {{(R10_W-SW_W){1'b0}}, speed_sw};
  end

  magnitude_cmp u_cmp (
    .a   (speed_sw_ext_s),
    .b   (rand10_q),
    .out (speed)
  );

  assign pattern = pattern_q;
  assign rand10  = rand10_q;

endmodule

// File: tb/tb_lfsr_mod_rng.sv
// Self-checking bench for lfsr_mod_rng: arithmetic LFSR model compared every
// cycle, plus hand-computed sequence, period and comparator expectations.
module tb_lfsr_mod_rng;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  speed_sw;
  logic [15:0] pattern;
  logic [9:0]  rand10;
  logic        speed;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;
  int  m_pat    = 0;
  int  m_r10    = 0;

  bit  seen_p [65536];
  bit  seen_r [1024];
  int  bad_p  = 0;
  int  bad_r  = 0;
  int  cnt64  = 0;

  always #5 clk = ~clk;

  lfsr_mod_rng dut (
    .clk      (clk),
    .reset    (reset),
    .speed_sw (speed_sw),
    .pattern  (pattern),
    .rand10   (rand10),
    .speed    (speed)
  );

  // Fibonacci step: shift left, new LSB = NOT(parity of tapped bits).
  function automatic int next16(input int s);
    int taps [4] = '{15, 13, 12, 10};
    int par = 0;
    foreach (taps[k]) par = par ^ ((s >> taps[k]) & 1);
    return ((s << 1) | (par ^ 1)) & 32'hFFFF;
  endfunction

  function automatic int next10(input int s);
    int taps [2] = '{9, 6};
    int par = 0;
    foreach (taps[k]) par = par ^ ((s >> taps[k]) & 1);
    return ((s << 1) | (par ^ 1)) & 32'h3FF;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hand-computed start-of-sequence values after reset release.
  task automatic check_trace(input int n);
    case (n)
      1:  begin check("pat_n1", int'(pattern), 32'h0001); check("r10_n1", int'(rand10), 32'h001); end
      2:  begin check("pat_n2", int'(pattern), 32'h0003); check("r10_n2", int'(rand10), 32'h003); end
      3:  check("pat_n3", int'(pattern), 32'h0007);
      7:  check("r10_n7", int'(rand10), 32'h07F);
      8:  check("r10_n8", int'(rand10), 32'h0FE);
      11: check("pat_n11", int'(pattern), 32'h07FF);
      12: check("pat_n12", int'(pattern), 32'h0FFE);
      default: ;
    endcase
  endtask

  // Reference model of the two registers.
  always @(posedge clk) begin
    if (reset) begin
      m_pat <= 0;
      m_r10 <= 0;
    end else begin
      m_pat <= next16(m_pat);
      m_r10 <= next10(m_r10);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pattern", int'(pattern), m_pat);
      check("rand10", int'(rand10), m_r10);
      check("speed", int'(speed), (int'(speed_sw) > m_r10) ? 1 : 0);
    end
  end

  initial begin
    reset    = 1'b1;
    speed_sw = 7'd0;
    repeat (3) tick();
    chk_en = 1'b1;

    check("rst_pattern", int'(pattern), 0);
    check("rst_rand10", int'(rand10), 0);
    #1 check("rst_speed_sw0", int'(speed), 0);
    speed_sw = 7'd5;
    #1 check("rst_speed_sw5", int'(speed), 1);

    // Release and run one full pattern period.
    reset = 1'b0;
    seen_p[0] = 1'b1;
    seen_r[0] = 1'b1;
    for (int n = 0; n <= 65535; n++) begin
      if (n > 0) begin
        tick();
        check_trace(n);
        if (n < 65535) begin
          if (pattern == 16'hFFFF || seen_p[pattern]) bad_p++;
          seen_p[pattern] = 1'b1;
        end else begin
          check("pat_period", int'(pattern), 0);
        end
        if (n < 1023) begin
          if (rand10 == 10'h3FF || seen_r[rand10]) bad_r++;
          seen_r[rand10] = 1'b1;
        end else if (n == 1023) begin
          check("r10_period", int'(rand10), 0);
        end
      end
      if (n < 1023) begin
        speed_sw = 7'd64;
        #1 if (speed) cnt64++;
      end else if (n < 2047) begin
        if (m_r10 == 126) begin
          speed_sw = 7'd127;
          #1 check("sw127_r126", int'(speed), 1);
        end else if (m_r10 == 127) begin
          speed_sw = 7'd127;
          #1 check("sw127_r127", int'(speed), 0);
        end else if (m_r10 == 0) begin
          speed_sw = 7'd5;
          #1 check("sw5_r0", int'(speed), 1);
        end else begin
          speed_sw = 7'd0;
          if (n == 1500) #1 check("sw0_any", int'(speed), 0);
        end
      end else begin
        speed_sw = 7'(n & 127);
      end
    end
    check("pat_no_repeat", bad_p, 0);
    check("r10_no_repeat", bad_r, 0);
    check("speed64_count", cnt64, 64);

    // Mid-run reset at clock 300, then re-trace the start sequence.
    speed_sw = 7'd33;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 300; n++) tick();
    reset = 1'b1;
    tick();
    check("mid_pat", int'(pattern), 0);
    check("mid_r10", int'(rand10), 0);
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check_trace(n);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
